// File: rtl/sat_fxnum_pipe.sv
// Two-stage valid/ready requantiser: Q(NBITS_IN,NBF_IN) -> Q(NBITS_OUT,NBF_OUT) with rounding, saturation and a sticky event counter.
// Optional macro SAT_FXNUM_SYMMETRIC_EN clamps the negative limit to -(2^(NBITS_OUT-1)-1).
module sat_fxnum_pipe #(
    parameter int NBITS_IN  = 8,
    parameter int NBF_IN    = 7,
    parameter int NBITS_OUT = 6,
    parameter int NBF_OUT   = 5,
    parameter int NCH       = 2,
    parameter int RND_MODE  = 1,
    parameter int CNT_W     = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NCH*NBITS_IN-1:0]  in_data,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic [NCH*NBITS_OUT-1:0] out_data,
    output logic [NCH-1:0]           out_sat,
    output logic                     out_valid,
    input  logic                     out_ready,
    input  logic                     cnt_clr,
    output logic [CNT_W-1:0]         sat_cnt
);

    localparam int D  = NBF_IN - NBF_OUT;
    localparam int W  = NBITS_IN + 1 - D;
    localparam int HS = (D > 0) ? D - 1 : 0;
    localparam logic signed [NBITS_IN:0]    HALF    = (NBITS_IN+1)'((D > 0) ? (1 << HS) : 0);
    localparam logic signed [NBITS_OUT-1:0] OUT_MAX = {1'b0, {(NBITS_OUT-1){1'b1}}};
    localparam logic signed [NBITS_OUT-1:0] OUT_MIN = {1'b1, {(NBITS_OUT-1){1'b0}}};
    localparam logic signed [NBITS_OUT-1:0] OUT_MIN_SYM = {1'b1, {(NBITS_OUT-2){1'b0}}, 1'b1};

    // One guard bit above the input keeps the rounding add from overflowing.
    function automatic logic signed [W-1:0] round_q(input logic signed [NBITS_IN-1:0] x);
        logic signed [NBITS_IN:0] ext;
        logic signed [NBITS_IN:0] bias;
        logic signed [NBITS_IN:0] sum;
        ext  = {x[NBITS_IN-1], x};
        bias = '0;
        if (D > 0) begin
            if (RND_MODE == 1)
                bias = HALF;
            else if (RND_MODE == 2)
                bias = HALF - (NBITS_IN+1)'(1) + {{NBITS_IN{1'b0}}, x[D]};
        end
        sum = ext + bias;
        sum = sum >>> D;
        return sum[W-1:0];
    endfunction

    // Returns {sat_flag, value}; in range when all bits above the output sign agree with it.
    function automatic logic [NBITS_OUT:0] sat_q(input logic signed [W-1:0] r);
        logic [W-NBITS_OUT:0]  top;
        logic [NBITS_OUT-1:0]  v;
        logic                  s;
        top = r[W-1:NBITS_OUT-1];
        if ((top == '0) || (top == '1)) begin
            v = r[NBITS_OUT-1:0];
            s = 1'b0;
        end else if (!r[W-1]) begin
            v = OUT_MAX;
            s = 1'b1;
        end else begin
            v = OUT_MIN;
            s = 1'b1;
        end
`ifdef SAT_FXNUM_SYMMETRIC_EN
        if (v == OUT_MIN) begin
            v = OUT_MIN_SYM;
            s = 1'b1;
        end
`endif
        return {s, v};
    endfunction

    logic                  adv;
    logic                  sat_inc;
    logic                  vld_p1;
    logic signed [W-1:0]   rnd_d  [NCH];
    logic signed [W-1:0]   rnd_p1 [NCH];
    logic [NCH*NBITS_OUT-1:0] data_d;
    logic [NCH-1:0]        sat_d;

    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;
    assign sat_inc  = out_valid && out_ready && (|out_sat);

    always_comb begin
        data_d = '0;
        sat_d  = '0;
        for (int ch = 0; ch < NCH; ch++) begin
            rnd_d[ch] = round_q(in_data[ch*NBITS_IN +: NBITS_IN]);
            {sat_d[ch], data_d[ch*NBITS_OUT +: NBITS_OUT]} = sat_q(rnd_p1[ch]);
        end
    end

    // Stage 1 registers rounded values; stage 2 registers saturated output.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_p1    <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sat   <= '0;
            for (int ch = 0; ch < NCH; ch++)
                rnd_p1[ch] <= '0;
        end else if (adv) begin
            vld_p1    <= in_valid;
            out_valid <= vld_p1;
            out_data  <= data_d;
            out_sat   <= sat_d;
            for (int ch = 0; ch < NCH; ch++)
                rnd_p1[ch] <= rnd_d[ch];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n)
            sat_cnt <= '0;
        else if (cnt_clr)
            sat_cnt <= sat_inc ? CNT_W'(1) : '0;
        else if (sat_inc && !(&sat_cnt))
            sat_cnt <= sat_cnt + 1'b1;
    end

endmodule

// File: tb/tb_sat_fxnum_pipe.sv
// Bench for sat_fxnum_pipe: four instances (modes 0/1/2 with 16-bit counter, mode 1 with 2-bit counter) share one stimulus stream.
module tb_sat_fxnum_pipe;

    localparam int NI = 8;
    localparam int FI = 7;
    localparam int NO = 6;
    localparam int FO = 5;
    localparam int DSH = FI - FO;
    localparam int MODE_OF [4] = '{0, 1, 2, 1};
    localparam int CMAX    [4] = '{65535, 65535, 65535, 3};

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] in_data;
    logic        in_valid;
    logic        out_ready;
    logic        cnt_clr;
    logic        ir [4];
    logic        ov [4];
    logic [11:0] od [4];
    logic [1:0]  os [4];
    logic [15:0] sc [3];
    logic [1:0]  sc2;

    int total = 0;
    int bad   = 0;
    int exp_cnt [4];
    logic [15:0] exp_q [$];

    always #5 clk = ~clk;

    sat_fxnum_pipe #(.NBITS_IN(NI), .NBF_IN(FI), .NBITS_OUT(NO), .NBF_OUT(FO), .NCH(2), .RND_MODE(0), .CNT_W(16)) u_m0 (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_ready(ir[0]),
        .out_data(od[0]), .out_sat(os[0]), .out_valid(ov[0]), .out_ready(out_ready), .cnt_clr(cnt_clr), .sat_cnt(sc[0]));
    sat_fxnum_pipe #(.NBITS_IN(NI), .NBF_IN(FI), .NBITS_OUT(NO), .NBF_OUT(FO), .NCH(2), .RND_MODE(1), .CNT_W(16)) u_m1 (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_ready(ir[1]),
        .out_data(od[1]), .out_sat(os[1]), .out_valid(ov[1]), .out_ready(out_ready), .cnt_clr(cnt_clr), .sat_cnt(sc[1]));
    sat_fxnum_pipe #(.NBITS_IN(NI), .NBF_IN(FI), .NBITS_OUT(NO), .NBF_OUT(FO), .NCH(2), .RND_MODE(2), .CNT_W(16)) u_m2 (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_ready(ir[2]),
        .out_data(od[2]), .out_sat(os[2]), .out_valid(ov[2]), .out_ready(out_ready), .cnt_clr(cnt_clr), .sat_cnt(sc[2]));
    sat_fxnum_pipe #(.NBITS_IN(NI), .NBF_IN(FI), .NBITS_OUT(NO), .NBF_OUT(FO), .NCH(2), .RND_MODE(1), .CNT_W(2)) u_c2 (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_ready(ir[3]),
        .out_data(od[3]), .out_sat(os[3]), .out_valid(ov[3]), .out_ready(out_ready), .cnt_clr(cnt_clr), .sat_cnt(sc2));

    // Reference: exact rational value x/2^D, rounded per mode, then clamped to the output range.
    function automatic logic [6:0] ref_ch(input logic [7:0] b, input int mode);
        int x, s, r, q, hi, lo;
        logic sat;
        logic [31:0] qv;
        x  = int'($signed(b));
        s  = 1 << DSH;
        r  = ((x % s) + s) % s;
        q  = (x - r) / s;
        if (mode == 1 && 2 * r >= s) q = q + 1;
        if (mode == 2 && (2 * r > s || (2 * r == s && (q % 2) != 0))) q = q + 1;
        hi = (1 << (NO - 1)) - 1;
        lo = -(1 << (NO - 1));
`ifdef SAT_FXNUM_SYMMETRIC_EN
        lo = -hi;
`endif
        sat = 1'b0;
        if (q > hi) begin q = hi; sat = 1'b1; end
        else if (q < lo) begin q = lo; sat = 1'b1; end
        qv = q;
        return {sat, qv[5:0]};
    endfunction

    task automatic chk(input string tag, input int k, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s dut%0d observed=%0h expected=%0h", tag, k, obs, expv);
        end
    endtask

    function automatic logic [31:0] cnt_of(input int k);
        if (k == 3) return 32'(sc2);
        return 32'(sc[k]);
    endfunction

    // One clock: score handshakes seen before the edge, advance, then check counters.
    task automatic cycle(output bit in_x);
        bit out_x;
        bit inc;
        logic [15:0] w;
        logic [6:0] e0, e1;
        #1;
        out_x = ov[0] && out_ready;
        in_x  = in_valid && ir[0];
        w     = '0;
        for (int k = 0; k < 4; k++)
            chk("in_ready", k, 32'(ir[k]), 32'(!ov[k] || out_ready));
        if (out_x) begin
            chk("out_expected", 0, 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) w = exp_q.pop_front();
        end
        for (int k = 0; k < 4; k++) begin
            inc = 1'b0;
            if (out_x) begin
                e0 = ref_ch(w[7:0], MODE_OF[k]);
                e1 = ref_ch(w[15:8], MODE_OF[k]);
                chk("out_data", k, 32'(od[k]), 32'({e1[5:0], e0[5:0]}));
                chk("out_sat", k, 32'(os[k]), 32'({e1[6], e0[6]}));
                inc = e0[6] | e1[6];
            end
            if (cnt_clr) exp_cnt[k] = inc ? 1 : 0;
            else if (inc && exp_cnt[k] < CMAX[k]) exp_cnt[k]++;
        end
        if (in_x) exp_q.push_back(in_data);
        @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < 4; k++)
            chk("sat_cnt", k, cnt_of(k), 32'(exp_cnt[k]));
    endtask

    initial begin
        bit ix;
        int w, c;
        logic [15:0] words [8];

        rst_n = 1'b0; in_valid = 1'b1; in_data = 16'($urandom); out_ready = 1'b1; cnt_clr = 1'b0;
        for (int k = 0; k < 4; k++) exp_cnt[k] = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            chk("rst_valid", k, 32'(ov[k]), 32'd0);
            chk("rst_data", k, 32'(od[k]), 32'd0);
            chk("rst_sat", k, 32'(os[k]), 32'd0);
            chk("rst_cnt", k, cnt_of(k), 32'd0);
        end

        // Limits word: ch0=0x7F, ch1=0x80; checks two-cycle latency.
        rst_n = 1'b1; in_data = 16'h807F; in_valid = 1'b1;
        cycle(ix);
        in_valid = 1'b0;
        for (int k = 0; k < 4; k++) chk("lat1_valid", k, 32'(ov[k]), 32'd0);
        cycle(ix);
        for (int k = 0; k < 4; k++) chk("lat2_valid", k, 32'(ov[k]), 32'd1);
        cycle(ix);

        // Rounding ties: ch0=0x06, ch1=0x0A.
        in_data = 16'h0A06; in_valid = 1'b1;
        cycle(ix);
        in_valid = 1'b0;
        repeat (3) cycle(ix);

        // Random stream with a three-cycle downstream stall.
        for (int i = 0; i < 8; i++) words[i] = 16'($urandom);
        w = 0; c = 0;
        while (w < 8 && c < 40) begin
            out_ready = !(c >= 3 && c < 6);
            in_valid  = 1'b1;
            in_data   = words[w];
            cycle(ix);
            if (ix) w++;
            c++;
        end
        chk("stream_accepted", 0, 32'(w), 32'd8);
        in_valid = 1'b0; out_ready = 1'b1;
        repeat (6) cycle(ix);
        chk("stream_drained", 0, 32'(exp_q.size()), 32'd0);

        // Counter edges: clear, then five saturating words on a 2-bit counter.
        cnt_clr = 1'b1;
        cycle(ix);
        cnt_clr = 1'b0;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_data  = {8'($urandom_range(0, 63)), 8'h7F};
            cycle(ix);
        end
        in_valid = 1'b0;
        repeat (3) cycle(ix);
        chk("cnt_sticky", 3, 32'(sc2), 32'd3);

        in_valid = 1'b1; in_data = 16'h007F;
        cycle(ix);
        in_valid = 1'b0;
        c = 0;
        while (c < 5) begin
            #1;
            if (ov[0]) begin
                cnt_clr = 1'b1;
                cycle(ix);
                cnt_clr = 1'b0;
                c = 10;
            end else begin
                cycle(ix);
                c++;
            end
        end
        chk("clr_seen", 3, 32'(c), 32'd10);
        chk("cnt_clr_inc", 3, 32'(sc2), 32'd1);
        repeat (3) cycle(ix);
        chk("final_drained", 0, 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
